// File: rtl/data_ram_responder.sv
// Word-addressed data RAM behind a waitrequest handshake.
// Every access takes WAIT_CYCLES wait states before completing.
module data_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,
    output logic        data_err
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             request;
    logic             complete;
    logic             abort;
    logic             commit;
    logic             bad_access;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign offset     = data_address - BASE_ADDR;
    assign idx        = offset[IDX_W+1:2];
    assign in_range   = (offset < SPAN);
    assign request    = data_read | data_write;
    assign commit     = complete & data_write & in_range;
    assign bad_access = request & (~in_range | (data_address[1:0] != 2'b00) |
                                   (data_read & data_write));

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        data_waitrequest = 1'b0;
        complete         = 1'b0;
        abort            = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    data_waitrequest = 1'b1;
                    state_next       = BUSY;
                    cnt_next         = CNT_LOAD;
                end
            end
            BUSY: begin
                if (!request) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt != 4'd0) begin
                    data_waitrequest = 1'b1;
                    cnt_next         = cnt - 4'd1;
                end else begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Read data is also loaded on the request edge so a one-wait-state read is valid in time.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_readdata <= 32'h0;
            data_err      <= 1'b0;
        end else begin
            if (state == BUSY || request) begin
                data_readdata <= in_range ? mem[idx] : 32'h0;
            end
            if (bad_access || abort) begin
                data_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_byteenable[i]) begin
                    mem[idx][8*i +: 8] <= data_writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (1 and 3 wait states) checked
// against a word-array reference model with sticky error tracking.
module tb_data_ram_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       rd, wr;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][3:0]  be;
    wire  [1:0]       waitreq, err;
    wire  [1:0][31:0] rdata;

    logic [31:0] model_mem   [2][DEPTH];
    logic [3:0]  model_known [2][DEPTH];
    bit          model_err   [2];
    logic [31:0] oob         [4] = '{32'h0000_0FFC, 32'h0000_2000, 32'hFFFF_FFFC, 32'h0000_0000};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_ram_responder #(
            .BASE_ADDR  (BASE),
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(g == 0 ? 1 : 3)
        ) dut (
            .clk             (clk),
            .reset           (reset),
            .data_address    (addr[g]),
            .data_read       (rd[g]),
            .data_write      (wr[g]),
            .data_writedata  (wdata[g]),
            .data_byteenable (be[g]),
            .data_waitrequest(waitreq[g]),
            .data_readdata   (rdata[g]),
            .data_err        (err[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit inRange(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
    endfunction

    // One complete handshake on instance d, checked against the model.
    task automatic applyStimulus(input int d, input bit do_rd, input bit do_wr, input logic [31:0] a,
                                 input logic [31:0] dat, input logic [3:0] b);
        int cycles;
        int idx;
        @(negedge clk);
        addr[d] = a; wdata[d] = dat; be[d] = b; rd[d] = do_rd; wr[d] = do_wr;
        #1;
        cycles = 0;
        while (waitreq[d] === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        checkOutput($sformatf("d%0d_wait_cycles", d), 32'(cycles), (d == 0) ? 32'd1 : 32'd3);
        idx = inRange(a) ? int'((a - BASE) >> 2) : 0;
        if (!inRange(a) || a[1:0] != 2'b00 || (do_rd && do_wr)) model_err[d] = 1'b1;
        if (do_rd && !do_wr) begin
            if (!inRange(a)) begin
                checkOutput($sformatf("d%0d_oob_read %h", d, a), rdata[d], 32'h0);
            end else if (model_known[d][idx] == 4'hF) begin
                checkOutput($sformatf("d%0d_read %h", d, a), rdata[d], model_mem[d][idx]);
            end else begin
                model_mem[d][idx]   = rdata[d];
                model_known[d][idx] = 4'hF;
            end
        end
        checkOutput($sformatf("d%0d_err", d), {31'b0, err[d]}, {31'b0, model_err[d]});
        @(negedge clk);
        rd[d] = 1'b0; wr[d] = 1'b0;
        if (do_wr && inRange(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    model_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
                    model_known[d][idx][i]      = 1'b1;
                end
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_err[0] = 1'b0;
        model_err[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("d%0d_rst_rdata", d), rdata[d], 32'h0);
            checkOutput($sformatf("d%0d_rst_err", d), {31'b0, err[d]}, 32'h0);
            checkOutput($sformatf("d%0d_rst_wait", d), {31'b0, waitreq[d]}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;
        model_err[0] = 1'b0; model_err[1] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) model_known[d][i] = 4'h0;
        repeat (2) @(negedge clk);
        doReset();

        // First read on the single-wait-state instance.
        applyStimulus(0, 1, 0, 32'h1000, 32'h0, 4'h0);

        // Full-word write then read back on both instances.
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 0, 1, 32'h1004, 32'hDEADBEEF, 4'hF);
            applyStimulus(d, 1, 0, 32'h1004, 32'h0, 4'h0);
            checkOutput($sformatf("d%0d_deadbeef", d), rdata[d], 32'hDEADBEEF);
        end

        // Byte lanes.
        applyStimulus(1, 0, 1, 32'h1008, 32'h11223344, 4'hF);
        applyStimulus(1, 0, 1, 32'h1008, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1, 1, 0, 32'h1008, 32'h0, 4'h0);
        checkOutput("byte_lanes", rdata[1], 32'h11BB33DD);

        // Known contents at the array edges and the reset-test word.
        applyStimulus(1, 0, 1, 32'h1000, $urandom, 4'hF);
        applyStimulus(1, 0, 1, 32'h1010, $urandom, 4'hF);
        applyStimulus(1, 0, 1, 32'h1FFC, $urandom, 4'hF);

        // Out-of-range accesses leave memory alone and latch the error.
        applyStimulus(1, 1, 0, 32'h0FFC, 32'h0, 4'h0);
        applyStimulus(1, 0, 1, 32'h2000, 32'hCAFEF00D, 4'hF);
        applyStimulus(1, 1, 0, 32'h1000, 32'h0, 4'h0);
        applyStimulus(1, 1, 0, 32'h1FFC, 32'h0, 4'h0);
        applyStimulus(1, 1, 0, 32'h1008, 32'h0, 4'h0);
        doReset();

        // Reset during the second busy cycle of a write.
        @(negedge clk);
        addr[1] = 32'h1010; wdata[1] = 32'h12345678; be[1] = 4'hF; wr[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr[1] = 1'b0;
        #1;
        checkOutput("midwrite_rdata", rdata[1], 32'h0);
        checkOutput("midwrite_err", {31'b0, err[1]}, 32'h0);
        applyStimulus(1, 1, 0, 32'h1010, 32'h0, 4'h0);

        // Read and write together act as a write and flag an error.
        applyStimulus(1, 1, 1, 32'h1014, 32'h0BADF00D, 4'hF);
        applyStimulus(1, 1, 0, 32'h1014, 32'h0, 4'h0);
        checkOutput("rdwr_commit", rdata[1], 32'h0BADF00D);
        doReset();

        // Request dropped mid-busy aborts to idle.
        @(negedge clk);
        addr[1] = 32'h1004; rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_err", {31'b0, err[1]}, 32'h1);
        checkOutput("abort_idle_wait", {31'b0, waitreq[1]}, 32'h0);
        model_err[1] = 1'b1;
        applyStimulus(1, 1, 0, 32'h1004, 32'h0, 4'h0);
        doReset();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int          d;
            int          sel;
            logic [31:0] a;
            bit          r;
            bit          w;
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 99));
            a   = BASE + 32'($urandom_range(0, 15)) * 32'd4;
            r   = 1'($urandom_range(0, 1));
            w   = !r;
            if (sel < 10) a = oob[$urandom_range(0, 3)];
            else if (sel < 18 && r) a = a + 32'($urandom_range(1, 3));
            else if (sel < 23) begin r = 1'b1; w = 1'b1; end
            applyStimulus(d, r, w, a, $urandom, 4'($urandom_range(0, 15)));
            if (n % 20 == 19) doReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Data-memory responder for the Harvard CPU's data port. Accepts word read/write requests from the datapath's data interface (`data_address`, `data_writedata`, `data_readdata`) and services them from an internal word array. Requests complete after a programmable number of wait states, signalled with a waitrequest handshake. The block takes the place of the bench's ideal combinational RAM, so the CPU's stall logic is exercised against a realistic memory.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: array depth in 32-bit words (power of two).
- `WAIT_CYCLES`, default 1: wait states per access (legal range 1..15).

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `data_address` input 32: byte address from the CPU.
- `data_read` input 1: read request.
- `data_write` input 1: write request.
- `data_writedata` input 32: write data.
- `data_byteenable` input 4: write lane enables; bit i covers byte [8i+7:8i].
- `data_waitrequest` output 1: high means the request is not yet accepted.
- `data_readdata` output 32: read data, registered.
- `data_err` output 1: sticky protocol/address error flag.

## Operation
- Word index: idx = (data_address − BASE_ADDR) >> 2. In range iff BASE_ADDR ≤ address < BASE_ADDR + 4·DEPTH_WORDS.
- Address bits [1:0] are ignored for indexing. Nonzero low bits set `data_err`.
- FSM has states IDLE and BUSY, plus a 4-bit counter `cnt`.
- IDLE, no request: stay in IDLE.
  - `data_waitrequest` = 0 in IDLE with no request.
- IDLE, `data_read` or `data_write` high:
  - `data_waitrequest` = 1 in the same cycle (combinational).
  - At the edge: `cnt` ← WAIT_CYCLES−1 and the FSM goes to BUSY.
- BUSY, `cnt` ≠ 0: `data_waitrequest` = 1 and `cnt` decrements.
- BUSY, `cnt` = 0: `data_waitrequest` = 0; this is the completion cycle. At the edge:
  - A write commits.
  - The FSM returns to IDLE.
- Reads:
  - `data_readdata` ← mem[idx] on every edge while in BUSY, so it is valid in the completion cycle.
  - An out-of-range read loads 0 and sets `data_err`.
- Writes:
  - Only enabled byte lanes are updated.
  - `data_byteenable` = 0 completes normally with no update.
  - An out-of-range write is dropped and sets `data_err`.
- `data_read` and `data_write` high together: treated as a write, and `data_err` is set.
- Request deasserted while in BUSY (protocol violation):
  - FSM aborts to IDLE at the next edge.
  - No write commits.
  - `data_err` is set.
- The master must hold address, data and byteenable stable while `data_waitrequest` = 1. The responder re-samples them every cycle and does not latch them.
- `data_err`, once set, is cleared only by `reset`.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0.
  - `data_readdata` = 32'h0, `data_err` = 0.
  - `data_waitrequest` = 0 (with no request present).
- Memory array contents are not reset and survive `reset`.
- Latency: a request first seen in cycle N completes in cycle N+WAIT_CYCLES.
  - Read data is valid in cycle N+WAIT_CYCLES.
  - A write is visible to a read issued in cycle N+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+1 cycles. The cycle after completion is IDLE and re-detects any held or new request.
- Reset in any cycle, including mid-BUSY or the completion cycle:
  - A pending write does not commit.
  - The FSM goes to IDLE next cycle.
- Reset has priority over all other events at the same edge.
- Wrap-around: `cnt` never underflows; BUSY with `cnt` = 0 always exits.

## Test plan
- Reset, then read 0x1000 with WAIT_CYCLES=1:
  - `data_waitrequest` is high 1 cycle, then low.
  - `data_readdata` reads back the array content at index 0.
  - `data_err` = 0.
- Write 0xDEADBEEF to 0x1004 (byteenable 4'hF), then read 0x1004:
  - The read returns 0xDEADBEEF.
  - With WAIT_CYCLES=3, `data_waitrequest` is high exactly 3 cycles per access.
- Byte lanes:
  - Write 0x11223344 to 0x1008 (4'hF).
  - Then write 0xAABBCCDD to 0x1008 with byteenable 4'b0101.
  - A read of 0x1008 returns 0x11BB33DD.
- Out-of-range accesses:
  - A read of 0x0000_0FFC returns 0 and sets `data_err`.
  - A write to 0x1000+4·1024 leaves all words unchanged.
  - `data_err` stays high until `reset`.
- Reset mid-write:
  - With WAIT_CYCLES=3, assert a write of 0x12345678 to 0x1010.
  - Pulse `reset` in the second BUSY cycle.
  - A subsequent read of 0x1010 returns its old value.
  - `data_readdata` = 0 immediately after reset.
- Protocol violations:
  - `data_read` and `data_write` high together commits the write and sets `data_err`.
  - Dropping `data_read` mid-BUSY returns the FSM to IDLE with `data_err` = 1.
